// File: rtl/horner_poly_seq_pkg.sv
// Shared Q-format definitions and rounding/saturation helpers for the tanh datapath.
// WIDTH must match the shared 16x16 signed multiplier.
package horner_poly_seq_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned FRAC  = 12;
    localparam int unsigned ONE   = 1 << FRAC;

    // Rounded product width: one guard bit above the full product.
    localparam int unsigned PW = 2 * WIDTH + 1;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StMul  = 2'd1;
    localparam state_t StAcc  = 2'd2;
    localparam state_t StDone = 2'd3;

    typedef struct packed {
        logic signed [WIDTH-1:0] val;
        logic                    clip;
    } sat_res_t;

    // Round half up toward +inf, then drop the fractional bits.
    function automatic logic signed [PW-1:0] rnd_shift(input logic signed [2*WIDTH-1:0] p);
        logic signed [PW-1:0] w;
        w = {p[2*WIDTH-1], p} + PW'(ONE >> 1);
        return w >>> FRAC;
    endfunction

    function automatic sat_res_t sat_w(input logic signed [PW-1:0] v);
        sat_res_t r;
        logic signed [PW-1:0] max_v;
        logic signed [PW-1:0] min_v;
        max_v = PW'((1 << (WIDTH - 1)) - 1);
        min_v = -max_v - PW'(1);
        if (v > max_v) begin
            r.val  = {1'b0, {(WIDTH-1){1'b1}}};
            r.clip = 1'b1;
        end else if (v < min_v) begin
            r.val  = {1'b1, {(WIDTH-1){1'b0}}};
            r.clip = 1'b1;
        end else begin
            r.val  = v[WIDTH-1:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/horner_poly_seq_if.sv
// Handshake and multiplier-operand bundle for the Horner evaluator.
// slave is the evaluator's view; master is the driving environment (source, sink, multiplier).
interface horner_poly_seq_if #(
    parameter int unsigned DEG = 3
);
    import horner_poly_seq_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          x_i;
    logic [(DEG+1)*WIDTH-1:0]  coef_i;
    logic [WIDTH-1:0]          mul_a_o;
    logic [WIDTH-1:0]          mul_b_o;
    logic [2*WIDTH-1:0]        mul_p_i;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          y_o;
    logic                      sat_o;

    modport slave (
        input  in_valid, x_i, coef_i, mul_p_i, out_ready,
        output in_ready, mul_a_o, mul_b_o, out_valid, y_o, sat_o
    );

    modport master (
        output in_valid, x_i, coef_i, mul_p_i, out_ready,
        input  in_ready, mul_a_o, mul_b_o, out_valid, y_o, sat_o
    );

endinterface

// File: rtl/horner_poly_seq_q_round_sat.sv
// Combinational round-shift of a full product, add of a WIDTH addend, clip back to WIDTH.
// Reusable by other tanh stages.
module horner_poly_seq_q_round_sat
    import horner_poly_seq_pkg::*;
(
    input  logic signed [2*WIDTH-1:0] prod_i,
    input  logic signed [WIDTH-1:0]   add_i,
    output logic signed [WIDTH-1:0]   res_o,
    output logic                      sat_o
);

    logic signed [PW-1:0] t;
    logic signed [PW-1:0] s;
    sat_res_t             r;

    always_comb begin
        t     = rnd_shift(prod_i);
        s     = t + {{(WIDTH+1){add_i[WIDTH-1]}}, add_i};
        r     = sat_w(s);
        res_o = r.val;
        sat_o = r.clip;
    end

endmodule

// File: rtl/horner_poly_seq.sv
// Sequential Horner evaluator: y = c0 + x*(c1 + x*(... + x*cDEG)), one multiply per two clocks
// using an external combinational multiplier; each step is rounded and saturated to WIDTH.
module horner_poly_seq #(
    parameter int unsigned DEG = 3
) (
    input logic              clk,
    input logic              rst_n,
    horner_poly_seq_if.slave bus
);
    import horner_poly_seq_pkg::*;

    localparam int unsigned KW = (DEG > 1) ? $clog2(DEG) : 1;

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         x_q, x_d;
    // cDEG goes straight into acc, so only c0..c(DEG-1) are kept.
    logic [DEG*WIDTH-1:0]     coef_q, coef_d;
    logic [WIDTH-1:0]         acc_q, acc_d;
    logic [KW-1:0]            k_q, k_d;
    logic [2*WIDTH-1:0]       prod_q, prod_d;
    logic                     sat_q, sat_d;
    logic [WIDTH-1:0]         y_q, y_d;
    logic                     sat_out_q, sat_out_d;

    logic [WIDTH-1:0]         ck;
    logic [WIDTH-1:0]         step_res;
    logic                     step_sat;

    assign ck = coef_q[int'(k_q)*WIDTH +: WIDTH];

    horner_poly_seq_q_round_sat u_round_sat (
        .prod_i (prod_q),
        .add_i  (ck),
        .res_o  (step_res),
        .sat_o  (step_sat)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        coef_d    = coef_q;
        acc_d     = acc_q;
        k_d       = k_q;
        prod_d    = prod_q;
        sat_d     = sat_q;
        y_d       = y_q;
        sat_out_d = sat_out_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    x_d     = bus.x_i;
                    coef_d  = bus.coef_i[DEG*WIDTH-1:0];
                    acc_d   = bus.coef_i[DEG*WIDTH +: WIDTH];
                    k_d     = KW'(DEG - 1);
                    sat_d   = 1'b0;
                    state_d = StMul;
                end
            end
            StMul: begin
                prod_d  = bus.mul_p_i;
                state_d = StAcc;
            end
            StAcc: begin
                acc_d = step_res;
                sat_d = sat_q | step_sat;
                if (k_q == '0) begin
                    y_d       = step_res;
                    sat_out_d = sat_q | step_sat;
                    state_d   = StDone;
                end else begin
                    k_d     = k_q - 1'b1;
                    state_d = StMul;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            x_q       <= '0;
            coef_q    <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            prod_q    <= '0;
            sat_q     <= 1'b0;
            y_q       <= '0;
            sat_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            coef_q    <= coef_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            prod_q    <= prod_d;
            sat_q     <= sat_d;
            y_q       <= y_d;
            sat_out_q <= sat_out_d;
        end
    end

    // Multiplier operands come straight from registers: no input-to-operand path.
    assign bus.mul_a_o   = acc_q;
    assign bus.mul_b_o   = x_q;
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.y_o       = y_q;
    assign bus.sat_o     = sat_out_q;

endmodule

// File: tb/tb_horner_poly_seq.sv
// Directed bench for horner_poly_seq with a behavioural multiplier and hand-computed results.
module tb_horner_poly_seq;
    import horner_poly_seq_pkg::*;

    localparam int unsigned DEG = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    horner_poly_seq_if #(.DEG(DEG)) bus ();

    horner_poly_seq #(.DEG(DEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mul_p_i = $signed(bus.mul_a_o) * $signed(bus.mul_b_o);

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int x, input int c0, input int c1, input int c2, input int c3);
        bus.x_i    = WIDTH'(x);
        bus.coef_i = {WIDTH'(c3), WIDTH'(c2), WIDTH'(c1), WIDTH'(c0)};
    endtask

    // Ticks until out_valid, starting the count at lat_in; bounded.
    task automatic wait_valid(input int lat_in, output int lat);
        lat = lat_in;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_job(input string tag, input int x, input int c0, input int c1,
                           input int c2, input int c3, input int exp_y, input int exp_sat);
        int lat;
        load(x, c0, c1, c2, c3);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        check_eq({tag, "/in_ready"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        wait_valid(0, lat);
        check_eq({tag, "/latency"}, lat, 2 * DEG);
        check_eq({tag, "/y"}, $signed(bus.y_o), exp_y);
        check_eq({tag, "/sat"}, bus.sat_o, exp_sat);
        tick();
        check_eq({tag, "/valid_drop"}, bus.out_valid, 0);
    endtask

    initial begin
        int lat;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        load(0, 0, 0, 0, 0);
        tick();
        tick();
        check_eq("rst/in_ready", bus.in_ready, 1);
        check_eq("rst/out_valid", bus.out_valid, 0);
        check_eq("rst/y", $signed(bus.y_o), 0);
        check_eq("rst/sat", bus.sat_o, 0);
        check_eq("rst/mul_a", bus.mul_a_o, 0);
        check_eq("rst/mul_b", bus.mul_b_o, 0);
        rst_n = 1'b1;
        tick();

        run_job("cube",     2048,   0,      0,      0,    4096,  512,    0);
        run_job("const",    12345,  4096,   0,      0,    0,     4096,   0);
        run_job("lin_neg",  -4096,  0,      4096,   0,    0,     -4096,  0);
        run_job("rnd_up",   1,      0,      2048,   0,    0,     1,      0);
        run_job("rnd_neg",  -1,     0,      2048,   0,    0,     0,      0);
        run_job("sat_pos",  16384,  32767,  32767,  0,    0,     32767,  1);
        run_job("sat_neg",  16384,  -32768, -32768, 0,    0,     -32768, 1);

        // Backpressure, plus in_valid and input changes while busy.
        bus.out_ready = 1'b0;
        load(2048, 100, 0, 0, 4096);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        load(-4096, 7, 7, 7, 7);
        tick();
        bus.in_valid = 1'b1;
        check_eq("busy/in_ready", bus.in_ready, 0);
        tick();
        tick();
        bus.in_valid = 1'b0;
        wait_valid(3, lat);
        check_eq("bp/latency", lat, 2 * DEG);
        check_eq("bp/y", $signed(bus.y_o), 612);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("bp/hold_valid", bus.out_valid, 1);
            check_eq("bp/hold_y", $signed(bus.y_o), 612);
        end
        bus.out_ready = 1'b1;
        tick();
        check_eq("bp/valid_drop", bus.out_valid, 0);
        check_eq("bp/in_ready_back", bus.in_ready, 1);
        tick();
        check_eq("bp/not_queued", bus.out_valid, 0);
        check_eq("bp/still_idle", bus.in_ready, 1);
        run_job("after_bp", 2048, 0, 0, 4096, 0, 1024, 0);

        // Reset while in ACC of step k=1.
        load(2048, 0, 0, 0, 4096);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("midrst/out_valid", bus.out_valid, 0);
        check_eq("midrst/in_ready", bus.in_ready, 1);
        check_eq("midrst/y", $signed(bus.y_o), 0);
        check_eq("midrst/sat", bus.sat_o, 0);
        rst_n = 1'b1;
        run_job("post_rst", 2048, 0, 0, 0, 4096, 512, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
